if_stage: RTL and testbench

Instruction fetch stage. Drives the PC and the instruction word into the decode stage (inst/pc_value), and sources instructions from instruction memory over a req/ack interface with one request outstanding. Honours the decode stall and takes branch redirects from the execute stage. A redirect flushes the decode input to a bubble and discards any in-flight fetch. One-entry hold buffer gives one fetch per cycle when memory acks in the same cycle.

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage.sv | 124 ++++++++++++
 tb/tb_if_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package if_stage_pkg;

  localparam int unsigned W_PC_DEF   = 16;
  localparam int unsigned W_INST_DEF = 32;
  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam logic [31:0] BUBBLE_INST = 32'hFE00_0000;

  // Bubble opcode 7'b1111111 sits in the top bits of the word.
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned OPC_LSB = 25;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: single-outstanding req/ack to imem, one-entry hold
// buffer for decode stalls, and branch redirect with in-flight discard.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned W_PC   = W_PC_DEF,
  parameter int unsigned W_INST = W_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [W_PC-1:0]   imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [W_INST-1:0] imem_data_i,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [W_PC-1:0]   br_target_i,
  output logic [W_INST-1:0] inst_o,
  output logic [W_PC-1:0]   pc_value_o,
  output logic              valid_o
);

  state_t state, state_nx;
  logic [W_PC-1:0]   fa_r, fa_nx, redir_r, redir_nx, buf_pc, buf_pc_nx, pc_nx;
  logic [W_INST-1:0] buf_inst, buf_inst_nx, inst_nx;
  logic              valid_nx;

  assign imem_req_o  = (state != HOLD);
  assign imem_addr_o = fa_r;

  always_comb begin
    state_nx    = state;
    fa_nx       = fa_r;
    redir_nx    = redir_r;
    buf_inst_nx = buf_inst;
    buf_pc_nx   = buf_pc;
    inst_nx     = inst_o;
    pc_nx       = pc_value_o;
    valid_nx    = valid_o;

    case (state)
      FETCH: begin
        if (br_taken_i) begin
          inst_nx  = W_INST'(BUBBLE_INST);
          valid_nx = 1'b0;
          if (imem_ack_i) begin
            fa_nx = br_target_i;
          end else begin
            redir_nx = br_target_i;
            state_nx = DRAIN;
          end
        end else if (stall_i) begin
          if (imem_ack_i) begin
            buf_inst_nx = imem_data_i;
            buf_pc_nx   = fa_r;
            fa_nx       = fa_r + 1'b1;
            state_nx    = HOLD;
          end
        end else if (imem_ack_i) begin
          inst_nx  = imem_data_i;
          pc_nx    = fa_r;
          valid_nx = 1'b1;
          fa_nx    = fa_r + 1'b1;
        end else begin
          inst_nx  = W_INST'(BUBBLE_INST);
          valid_nx = 1'b0;
        end
      end
      HOLD: begin
        if (br_taken_i) begin
          inst_nx  = W_INST'(BUBBLE_INST);
          valid_nx = 1'b0;
          fa_nx    = br_target_i;
          state_nx = FETCH;
        end else if (!stall_i) begin
          inst_nx  = buf_inst;
          pc_nx    = buf_pc;
          valid_nx = 1'b1;
          state_nx = FETCH;
        end
      end
      DRAIN: begin
        // The discarded request keeps the old address until memory acks it.
        inst_nx  = W_INST'(BUBBLE_INST);
        valid_nx = 1'b0;
        if (br_taken_i) begin
          if (imem_ack_i) begin
            fa_nx    = br_target_i;
            state_nx = FETCH;
          end else begin
            redir_nx = br_target_i;
          end
        end else if (imem_ack_i) begin
          fa_nx    = redir_r;
          state_nx = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      fa_r       <= W_PC'(RESET_PC);
      redir_r    <= '0;
      buf_inst   <= '0;
      buf_pc     <= '0;
      inst_o     <= W_INST'(BUBBLE_INST);
      pc_value_o <= '0;
      valid_o    <= 1'b0;
    end else begin
      state      <= state_nx;
      fa_r       <= fa_nx;
      redir_r    <= redir_nx;
      buf_inst   <= buf_inst_nx;
      buf_pc     <= buf_pc_nx;
      inst_o     <= inst_nx;
      pc_value_o <= pc_nx;
      valid_o    <= valid_nx;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed bench for if_stage against a transaction-level
// fetch model with a latency-programmable instruction memory.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        stall_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [15:0] br_target_i = '0;
  logic [31:0] inst_o;
  logic [15:0] pc_value_o;
  logic        valid_o;

  if_stage dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .stall_i(stall_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .inst_o(inst_o), .pc_value_o(pc_value_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch pointer, parked instruction queue, pending discard.
  typedef struct {
    logic [31:0] inst;
    logic [15:0] pc;
  } item_t;
  item_t       parked[$];
  logic [15:0] m_next;
  bit          m_discard;
  logic [15:0] m_redir;
  logic [31:0] e_inst;
  logic [15:0] e_pc;
  bit          e_valid;

  task automatic model_reset();
    parked.delete();
    m_next = RESET_PC; m_discard = 0; m_redir = '0;
    e_inst = BUBBLE_INST; e_pc = '0; e_valid = 0;
  endtask

  task automatic bubble();
    e_inst = BUBBLE_INST; e_valid = 0;
  endtask

  task automatic model_step(input bit ack, input logic [31:0] data, input bit stall,
                            input bit br, input logic [15:0] tgt);
    item_t it;
    if (m_discard) begin
      bubble();
      if (br && ack) begin m_discard = 0; m_next = tgt; end
      else if (br) m_redir = tgt;
      else if (ack) begin m_discard = 0; m_next = m_redir; end
    end else if (parked.size() > 0) begin
      if (br) begin parked.delete(); m_next = tgt; bubble(); end
      else if (!stall) begin
        it = parked.pop_front();
        e_inst = it.inst; e_pc = it.pc; e_valid = 1;
      end
    end else if (br) begin
      bubble();
      if (ack) m_next = tgt;
      else begin m_discard = 1; m_redir = tgt; end
    end else if (stall) begin
      if (ack) begin
        it.inst = data; it.pc = m_next;
        parked.push_back(it);
        m_next = m_next + 16'd1;
      end
    end else if (ack) begin
      e_inst = data; e_pc = m_next; e_valid = 1;
      m_next = m_next + 16'd1;
    end else bubble();
  endtask

  // Memory: latency in cycles beyond the first; -1 picks it at random per request.
  int  mem_lat  = 0;
  bit  mem_busy = 0;
  int  mem_wait = 0;
  bit  rand_data = 0;

  task automatic step(input bit stall, input bit br, input logic [15:0] tgt);
    bit          ack;
    logic [31:0] data;
    check_eq("inst", inst_o, e_inst);
    check_eq("pc", {16'h0, pc_value_o}, {16'h0, e_pc});
    check_eq("valid", {31'h0, valid_o}, {31'h0, e_valid});
    check_eq("req", {31'h0, imem_req_o}, {31'h0, (parked.size() == 0)});
    if (parked.size() == 0) check_eq("addr", {16'h0, imem_addr_o}, {16'h0, m_next});
    ack = 0;
    if (imem_req_o) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_wait = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
      end
      if (mem_wait == 0) begin ack = 1; mem_busy = 0; end
      else mem_wait--;
    end else mem_busy = 0;
    data = rand_data ? $urandom : ({16'h0, imem_addr_o} + 32'h100);
    imem_ack_i  = ack;
    imem_data_i = data;
    stall_i     = stall;
    br_taken_i  = br;
    br_target_i = tgt;
    model_step(ack, data, stall, br, tgt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_ack_i = 0; stall_i = 0; br_taken_i = 0;
    mem_busy = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int k;
    @(negedge clk);
    do_reset();

    // Back-to-back fetch, then a 3-cycle stall when address 5 is acked.
    mem_lat = 0;
    for (int i = 0; i < 5; i++) step(0, 0, '0);
    check_eq("b2b_inst", inst_o, 32'h104);
    for (int i = 0; i < 3; i++) step(1, 0, '0);
    check_eq("hold_pc", {16'h0, pc_value_o}, 32'h4);
    step(0, 0, '0);
    check_eq("rel_inst", inst_o, 32'h105);
    check_eq("rel_pc", {16'h0, pc_value_o}, 32'h5);
    for (int i = 0; i < 3; i++) step(0, 0, '0);

    // Three-cycle memory latency: two bubbles per instruction.
    mem_lat = 2;
    for (int i = 0; i < 9; i++) step(0, 0, '0);

    // Redirect while a request is pending.
    do_reset();
    mem_lat = 0;
    for (int i = 0; i < 7; i++) step(0, 0, '0);
    mem_lat = 2;
    step(0, 0, '0);
    step(0, 1, 16'h0040);
    mem_lat = 0;
    k = 0;
    while (!valid_o && k < 10) begin step(0, 0, '0); k++; end
    check_eq("redir_pc", {16'h0, pc_value_o}, 32'h40);
    check_eq("redir_inst", inst_o, 32'h140);

    // Redirect together with stall while holding.
    step(1, 0, '0);
    step(1, 1, 16'h0020);
    check_eq("hold_br_valid", {31'h0, valid_o}, 32'h0);
    step(0, 0, '0);
    check_eq("hold_br_pc", {16'h0, pc_value_o}, 32'h20);

    // Wrap from FFFF to 0000.
    step(0, 1, 16'hFFFF);
    step(0, 0, '0);
    check_eq("wrap_pc0", {16'h0, pc_value_o}, 32'hFFFF);
    step(0, 0, '0);
    check_eq("wrap_pc1", {16'h0, pc_value_o}, 32'h0);

    // Random traffic with a reset dropped in mid-run.
    mem_lat = -1;
    rand_data = 1;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, 16'($urandom));
    end
    step(0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
